// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter through its start/data/busy handshake.
// Optional sticky overflow flag is built when TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
   parameter int unsigned DEPTH_LOG2    = 4,
   parameter int unsigned BUSY_WAIT_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   input  logic                  tx_busy,
   output logic                  ovf,
   input  logic                  ovf_clr
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned WW    = $clog2(BUSY_WAIT_MAX + 1);
   localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
   localparam logic [WW-1:0]         WAIT_LAST = WW'(BUSY_WAIT_MAX - 1);
   localparam logic [WW-1:0]         WAIT_ONE  = WW'(1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t                 state, state_nxt;
   logic [7:0]             mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
   logic [WW-1:0]          wait_cnt;
   logic [DEPTH_LOG2:0]    count_nxt;
   logic                   push, pop, wait_clr, wait_inc;

   // Writes are gated by the registered full flag, even when a pop happens in the same cycle.
   assign push = wr_en & ~full;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      wait_clr  = 1'b0;
      wait_inc  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && !tx_busy) begin
               pop       = 1'b1;
               wait_clr  = 1'b1;
               state_nxt = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (tx_busy)                    state_nxt = WAIT_DONE;
            else if (wait_cnt == WAIT_LAST) state_nxt = IDLE;
            else                            wait_inc  = 1'b1;
         end
         WAIT_DONE: begin
            if (!tx_busy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      count_nxt = count;
      if (push && !pop)      count_nxt = count + CNT_ONE;
      else if (pop && !push) count_nxt = count - CNT_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         tx_start <= 1'b0;
         tx_data  <= '0;
         wait_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            rd_ptr  <= rd_ptr + PTR_ONE;
            tx_data <= mem[rd_ptr];
         end
         tx_start <= pop;
         count    <= count_nxt;
         full     <= (count_nxt == DEPTH_CNT);
         empty    <= (count_nxt == '0);
         if (wait_clr)      wait_cnt <= '0;
         else if (wait_inc) wait_cnt <= wait_cnt + WAIT_ONE;
      end
   end

`ifdef TX_FIFO_OVF_EN
   // A same-cycle overflow takes priority over the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 ovf <= 1'b0;
      else if (wr_en && full)  ovf <= 1'b1;
      else if (ovf_clr)        ovf <= 1'b0;
   end
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr;
   assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a simple UART busy model
// (busy rises one cycle after tx_start and stays high for 160 cycles).
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       ovf_clr = 1'b0;
   logic       full, empty, tx_start, ovf;
   logic [4:0] count;
   logic [7:0] tx_data;
   logic       tx_busy;

   logic model_busy = 1'b0;
   logic hold_busy  = 1'b0;
   logic model_en   = 1'b0;
   logic dly        = 1'b0;
   logic prev_start = 1'b0;
   int   bcnt       = 0;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int dbl_pulse   = 0;
   int start_busy  = 0;
   logic [7:0] got[$];
   int         start_cyc[$];

`ifdef TX_FIFO_OVF_EN
   localparam logic EXP_OVF = 1'b1;
`else
   localparam logic EXP_OVF = 1'b0;
`endif

   assign tx_busy = model_busy | hold_busy;

   uart_tx_fifo #(.DEPTH_LOG2(4), .BUSY_WAIT_MAX(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .count(count),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Launch monitor followed by the transmitter model, one process to keep ordering fixed.
   always @(negedge clk) begin
      if (tx_start) begin
         got.push_back(tx_data);
         start_cyc.push_back(cyc);
         if (prev_start) dbl_pulse++;
         if (tx_busy)    start_busy++;
      end
      prev_start = tx_start;
      if (bcnt != 0) begin
         bcnt--;
         if (bcnt == 0) model_busy = 1'b0;
      end else if (dly) begin
         dly = 1'b0;
         model_busy = 1'b1;
         bcnt = 160;
      end else if (model_en && tx_start) begin
         dly = 1'b1;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drain(input int n, input int budget, output bit ok);
      int quiet = 0;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (tx_busy) quiet = 0;
         else         quiet++;
         if (got.size() >= n && quiet >= 4 && empty) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      vectors++; if (empty !== 1'b1)    begin miscompares++; $display("FAIL reset_empty: got %0b want 1", empty); end
      vectors++; if (full !== 1'b0)     begin miscompares++; $display("FAIL reset_full: got %0b want 0", full); end
      vectors++; if (count !== 5'd0)    begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
      vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start: got %0b want 0", tx_start); end
      vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %0h want 00", tx_data); end
      vectors++; if (ovf !== 1'b0)      begin miscompares++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
      rst = 1'b0;
      got.delete();
      repeat (50) step();
      vectors++; if (got.size() != 0) begin miscompares++; $display("FAIL idle_launches: got %0d want 0", got.size()); end
   endtask

   task automatic test_single();
      bit ok;
      got.delete();
      model_en = 1'b1;
      wr_en = 1'b1; wr_data = 8'h41;
      step();
      wr_en = 1'b0;
      vectors++; if (count !== 5'd1)    begin miscompares++; $display("FAIL single_count1: got %0d want 1", count); end
      vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL single_no_early_start: got %0b want 0", tx_start); end
      step();
      vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL single_start_latency: got %0b want 1", tx_start); end
      vectors++; if (tx_data !== 8'h41) begin miscompares++; $display("FAIL single_tx_data: got %0h want 41", tx_data); end
      drain(1, 600, ok);
      vectors++; if (!ok)               begin miscompares++; $display("FAIL single_drain_timeout: got 0 want 1"); end
      vectors++; if (got.size() != 1)   begin miscompares++; $display("FAIL single_launches: got %0d want 1", got.size()); end
      vectors++; if (got[0] !== 8'h41)  begin miscompares++; $display("FAIL single_byte: got %0h want 41", got[0]); end
      vectors++; if (count !== 5'd0)    begin miscompares++; $display("FAIL single_count0: got %0d want 0", count); end
      vectors++; if (dbl_pulse != 0)    begin miscompares++; $display("FAIL single_pulse_width: got %0d want 0", dbl_pulse); end
   endtask

   task automatic test_burst();
      bit ok;
      got.delete();
      hold_busy = 1'b1;
      wr_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_data = 8'(i + 1);
         step();
      end
      wr_en = 1'b0;
      vectors++; if (full !== 1'b1)   begin miscompares++; $display("FAIL burst_full: got %0b want 1", full); end
      vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL burst_count: got %0d want 16", count); end
      vectors++; if (empty !== 1'b0)  begin miscompares++; $display("FAIL burst_empty: got %0b want 0", empty); end
      hold_busy = 1'b0;
      drain(16, 4000, ok);
      vectors++; if (!ok)             begin miscompares++; $display("FAIL burst_drain_timeout: got 0 want 1"); end
      vectors++; if (got.size() != 16) begin miscompares++; $display("FAIL burst_launches: got %0d want 16", got.size()); end
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if (got[i] !== 8'(i + 1)) begin miscompares++; $display("FAIL burst_order[%0d]: got %0h want %0h", i, got[i], 8'(i + 1)); end
      end
      vectors++; if (start_busy != 0) begin miscompares++; $display("FAIL burst_start_while_busy: got %0d want 0", start_busy); end
      vectors++; if (dbl_pulse != 0)  begin miscompares++; $display("FAIL burst_pulse_width: got %0d want 0", dbl_pulse); end
   endtask

   task automatic test_overflow();
      bit ok;
      got.delete();
      hold_busy = 1'b1;
      wr_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_data = 8'(8'h20 + i);
         step();
      end
      wr_data = 8'hEE;
      step();
      wr_en = 1'b0;
      vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL ovf_count: got %0d want 16", count); end
      vectors++; if (ovf !== EXP_OVF) begin miscompares++; $display("FAIL ovf_set: got %0b want %0b", ovf, EXP_OVF); end
      wr_en = 1'b1; ovf_clr = 1'b1;
      step();
      wr_en = 1'b0;
      vectors++; if (ovf !== EXP_OVF) begin miscompares++; $display("FAIL ovf_set_wins: got %0b want %0b", ovf, EXP_OVF); end
      step();
      ovf_clr = 1'b0;
      vectors++; if (ovf !== 1'b0)    begin miscompares++; $display("FAIL ovf_clear: got %0b want 0", ovf); end
      hold_busy = 1'b0;
      drain(16, 4000, ok);
      vectors++; if (!ok)              begin miscompares++; $display("FAIL ovf_drain_timeout: got 0 want 1"); end
      vectors++; if (got.size() != 16) begin miscompares++; $display("FAIL ovf_launches: got %0d want 16", got.size()); end
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if (got[i] !== 8'(8'h20 + i)) begin miscompares++; $display("FAIL ovf_order[%0d]: got %0h want %0h", i, got[i], 8'(8'h20 + i)); end
      end
   endtask

   task automatic test_wrap();
      bit ok;
      int j;
      got.delete();
      wr_en = 1'b1; wr_data = 8'h50;
      step();
      vectors++; if (count !== 5'd1)    begin miscompares++; $display("FAIL wrap_count_first: got %0d want 1", count); end
      wr_data = 8'h51;
      step();
      wr_en = 1'b0;
      vectors++; if (count !== 5'd1)    begin miscompares++; $display("FAIL wrap_count_simul: got %0d want 1", count); end
      vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL wrap_simul_start: got %0b want 1", tx_start); end
      vectors++; if (tx_data !== 8'h50) begin miscompares++; $display("FAIL wrap_simul_data: got %0h want 50", tx_data); end
      for (int i = 2; i < 24; i++) begin
         for (j = 0; j < 400 && full; j++) step();
         vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL wrap_space_timeout: got %0b want 0", full); end
         wr_en = 1'b1; wr_data = 8'(8'h50 + i);
         step();
         wr_en = 1'b0;
      end
      drain(24, 6000, ok);
      vectors++; if (!ok)              begin miscompares++; $display("FAIL wrap_drain_timeout: got 0 want 1"); end
      vectors++; if (got.size() != 24) begin miscompares++; $display("FAIL wrap_launches: got %0d want 24", got.size()); end
      for (int i = 0; i < 24; i++) begin
         vectors++;
         if (got[i] !== 8'(8'h50 + i)) begin miscompares++; $display("FAIL wrap_order[%0d]: got %0h want %0h", i, got[i], 8'(8'h50 + i)); end
      end
   endtask

   task automatic test_timeout_reset();
      bit ok;
      int j;
      got.delete();
      start_cyc.delete();
      model_en = 1'b0;
      wr_en = 1'b1; wr_data = 8'h71;
      step();
      wr_data = 8'h72;
      step();
      wr_en = 1'b0;
      drain(2, 100, ok);
      repeat (8) step();
      vectors++; if (!ok)               begin miscompares++; $display("FAIL timeout_drain: got 0 want 1"); end
      vectors++; if (got.size() != 2)   begin miscompares++; $display("FAIL timeout_launches: got %0d want 2", got.size()); end
      vectors++; if (got[0] !== 8'h71)  begin miscompares++; $display("FAIL timeout_byte0: got %0h want 71", got[0]); end
      vectors++; if (got[1] !== 8'h72)  begin miscompares++; $display("FAIL timeout_byte1: got %0h want 72", got[1]); end
      vectors++;
      if (start_cyc[1] - start_cyc[0] != 5) begin
         miscompares++; $display("FAIL timeout_spacing: got %0d want 5", start_cyc[1] - start_cyc[0]);
      end
      // Reset while the transmitter is busy with the first of six bytes.
      model_en = 1'b1;
      wr_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_data = 8'(8'h80 + i);
         step();
      end
      wr_en = 1'b0;
      for (j = 0; j < 20 && !tx_busy; j++) step();
      vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL rst_busy_timeout: got %0b want 1", tx_busy); end
      repeat (3) step();
      vectors++; if (count !== 5'd5)   begin miscompares++; $display("FAIL rst_pre_count: got %0d want 5", count); end
      rst = 1'b1;
      #1;
      vectors++; if (count !== 5'd0)   begin miscompares++; $display("FAIL rst_async_count: got %0d want 0", count); end
      vectors++; if (empty !== 1'b1)   begin miscompares++; $display("FAIL rst_async_empty: got %0b want 1", empty); end
      step();
      rst = 1'b0;
      got.delete();
      repeat (250) step();
      vectors++; if (got.size() != 0)  begin miscompares++; $display("FAIL rst_discard: got %0d want 0", got.size()); end
      vectors++; if (empty !== 1'b1)   begin miscompares++; $display("FAIL rst_final_empty: got %0b want 1", empty); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_wrap();
      test_timeout_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
